placed_ctrl: RTL and testbench
==============================

PLACED_CTRL -- requirements
Module: placed_ctrl

Interface
REQ-001 Parameter SIZE, default 8: width of one board-cell entry; value 0 means the cell is empty.
REQ-002 Parameter DEPTH, default 45: number of board cells; AW = $clog2(DEPTH), CW = $clog2(DEPTH+1).
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  controller can accept a command.
REQ-007 cmd_op  in  2  00 QUERY, 01 PLACE, 10 REMOVE, 11 CLEAR.
REQ-008 cmd_addr  in  AW  target cell; ignored for CLEAR.
REQ-009 cmd_data  in  SIZE  card code for PLACE; ignored otherwise.
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_status  out  2  00 OK, 01 OCCUPIED, 10 EMPTY, 11 INVALID.
REQ-012 rsp_data  out  SIZE  cell content read; 0 for CLEAR and INVALID.
REQ-013 occupied_count  out  CW  number of non-empty cells.
REQ-014 ram_address  out  AW, ram_write_data  out  SIZE, ram_write_en  out  1: board RAM write side.
REQ-015 ram_read_data  in  SIZE: board RAM read data, registered one cycle after ram_address.

Function
REQ-016 States: IDLE, RD, CHK, CLR, RSP; cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-017 On acceptance, op/addr/data SHALL be registered; the command inputs are not sampled again until the controller returns to IDLE.
REQ-018 QUERY/PLACE/REMOVE with cmd_addr >= DEPTH, or PLACE with cmd_data == 0, SHALL go IDLE->RSP with status INVALID and no RAM write.
REQ-019 Valid QUERY/PLACE/REMOVE: IDLE->RD->CHK->RSP; ram_address = registered address in RD and CHK.
REQ-020 In CHK, QUERY: rsp_data = ram_read_data; status OK if non-zero, else EMPTY.
REQ-021 In CHK, PLACE: if ram_read_data == 0, ram_write_en=1, ram_write_data=cmd data, occupied_count+1, status OK; else no write, status OCCUPIED; rsp_data = old content.
REQ-022 In CHK, REMOVE: if ram_read_data != 0, ram_write_en=1, ram_write_data=0, occupied_count-1, status OK; else status EMPTY; rsp_data = old content.
REQ-023 CLEAR: CLR writes 0 to addresses 0..DEPTH-1, one per cycle, ascending; then RSP, status OK; occupied_count SHALL be 0 from the RSP cycle onward.
REQ-024 Latency from acceptance edge T: rsp_valid high in cycle T+3 for a valid cell op, T+1 for INVALID, T+DEPTH+1 for CLEAR.
REQ-025 RSP lasts exactly one cycle, then IDLE; rsp_status/rsp_data hold their value until the next response.
REQ-026 ram_write_en SHALL be 0 outside CHK and CLR; at most one RAM write per cycle.
REQ-027 occupied_count SHALL never exceed DEPTH or underflow below 0.
REQ-028 A command presented in the RSP cycle SHALL NOT be accepted; it is accepted in the next IDLE cycle.

Reset
REQ-029 On rst_n low: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_status=00, rsp_data=0, occupied_count=0, ram_address=0, ram_write_data=0, ram_write_en=0.
REQ-030 Reset during CLR or any command SHALL abort it with no response; board RAM content is then undefined, and software issues CLEAR after reset.

Structure
REQ-031 A shared package SHALL hold the op codes, the status codes, and the EMPTY=0 constant.
REQ-032 A single flat module; the clear address counter and occupied counter are internal registers; no sub-module.

Verification
REQ-033 Bench: DUT connected to the board RAM block, DEPTH=8, SIZE=8; issue CLEAR first -> rsp_valid 9 cycles after accept, status OK, occupied_count 0.
REQ-034 PLACE addr 3 data 0x15 -> status OK at T+3; QUERY addr 3 -> rsp_data 0x15, status OK; occupied_count 1.
REQ-035 PLACE addr 3 data 0x22 again -> status OCCUPIED, rsp_data 0x15, count stays 1; REMOVE addr 3 -> OK, rsp_data 0x15, count 0; REMOVE addr 3 -> EMPTY.
REQ-036 PLACE addr 9 (>= DEPTH) and PLACE addr 2 data 0 -> INVALID at T+1, no ram_write_en pulse.
REQ-037 Fill all 8 cells -> count 8; CLEAR -> count 0 and every QUERY returns EMPTY.
REQ-038 Assert rst_n low mid-CLEAR at the 4th write -> no rsp_valid, all outputs at reset values, cmd_ready=1 after release.

Source files
------------

// File: rtl/placed_ctrl_pkg.sv
// Shared definitions for the card-placement board controller.
//   op_e     : command opcodes carried on cmd_op
//   status_e : response codes carried on rsp_status
//   state_e  : controller FSM states
//   EMPTY    : cell content meaning "no card"
package placed_ctrl_pkg;

    localparam int EMPTY = 0;

    typedef enum logic [1:0] {
        OP_QUERY  = 2'b00,
        OP_PLACE  = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_OCCUPIED = 2'b01,
        ST_EMPTY    = 2'b10,
        ST_INVALID  = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_CLR,
        S_RSP
    } state_e;

endpackage

// File: rtl/placed_ctrl.sv
// Board controller: accepts QUERY/PLACE/REMOVE/CLEAR commands against an
// external board RAM (registered read, one cycle latency) and tracks how many
// cells hold a card.
//   clk, rst_n                    : clock, async active-low reset
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_op, cmd_addr, cmd_data    : command fields
//   rsp_valid                     : one-cycle response pulse
//   rsp_status, rsp_data          : held response fields
//   occupied_count                : number of non-empty cells
//   ram_address, ram_write_data,
//   ram_write_en, ram_read_data   : board RAM port
module placed_ctrl
    import placed_ctrl_pkg::*;
#(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 45,
    parameter  int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [SIZE-1:0] cmd_data,
    output logic            rsp_valid,
    output logic [1:0]      rsp_status,
    output logic [SIZE-1:0] rsp_data,
    output logic [CW-1:0]   occupied_count,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [AW-1:0]   addr_q;
    logic [SIZE-1:0] data_q;
    logic [AW-1:0]   clr_cnt;
    logic [CW-1:0]   count_q;
    logic [1:0]      status_q;
    logic [SIZE-1:0] rdata_q;

    logic accept, cmd_bad, old_empty, clr_last;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    // Out-of-range cell or placing the empty code is rejected without touching RAM.
    assign cmd_bad   = ({1'b0, cmd_addr} >= (AW + 1)'(DEPTH)) ||
                       ((op_e'(cmd_op) == OP_PLACE) && (cmd_data == SIZE'(EMPTY)));
    assign old_empty = (ram_read_data == SIZE'(EMPTY));
    assign clr_last  = (clr_cnt == AW'(DEPTH - 1));

    assign rsp_status     = status_q;
    assign rsp_data       = rdata_q;
    assign occupied_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        ram_address    = '0;
        ram_write_data = '0;
        ram_write_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (op_e'(cmd_op) == OP_CLEAR) state_d = S_CLR;
                    else if (cmd_bad)              state_d = S_RSP;
                    else                           state_d = S_RD;
                end
            end
            S_RD: begin
                ram_address = addr_q;
                state_d     = S_CHK;
            end
            S_CHK: begin
                ram_address = addr_q;
                state_d     = S_RSP;
                if (op_q == OP_PLACE && old_empty) begin
                    ram_write_en   = 1'b1;
                    ram_write_data = data_q;
                end
                if (op_q == OP_REMOVE && !old_empty) begin
                    ram_write_en   = 1'b1;
                    ram_write_data = SIZE'(EMPTY);
                end
            end
            S_CLR: begin
                ram_address  = clr_cnt;
                ram_write_en = 1'b1;
                if (clr_last) state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_QUERY;
            addr_q   <= '0;
            data_q   <= '0;
            clr_cnt  <= '0;
            count_q  <= '0;
            status_q <= ST_OK;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q    <= op_e'(cmd_op);
                    addr_q  <= cmd_addr;
                    data_q  <= cmd_data;
                    clr_cnt <= '0;
                    if (op_e'(cmd_op) != OP_CLEAR && cmd_bad) begin
                        status_q <= ST_INVALID;
                        rdata_q  <= '0;
                    end
                end
                S_CHK: begin
                    rdata_q <= ram_read_data;
                    case (op_q)
                        OP_PLACE: begin
                            status_q <= old_empty ? ST_OK : ST_OCCUPIED;
                            if (old_empty && count_q < CW'(DEPTH)) count_q <= count_q + 1'b1;
                        end
                        OP_REMOVE: begin
                            status_q <= old_empty ? ST_EMPTY : ST_OK;
                            if (!old_empty && count_q != '0) count_q <= count_q - 1'b1;
                        end
                        default: status_q <= old_empty ? ST_EMPTY : ST_OK;
                    endcase
                end
                S_CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    // Count and response settle on the last write so RSP already shows 0.
                    if (clr_last) begin
                        count_q  <= '0;
                        status_q <= ST_OK;
                        rdata_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_placed_ctrl.sv
// Bench for placed_ctrl: board RAM model, reference board model, directed
// scenarios then randomized commands.
module tb_placed_ctrl;

    localparam int DEPTH = 8;
    localparam int SIZE  = 8;
    localparam int AW    = 4;
    localparam int CW    = 4;

    localparam logic [1:0] QUERY = 2'b00, PLACE = 2'b01, REMOVE = 2'b10, CLEAR = 2'b11;
    localparam int OK = 0, OCC = 1, EMP = 2, INV = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = '0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [SIZE-1:0] cmd_data = '0;
    logic            rsp_valid;
    logic [1:0]      rsp_status;
    logic [SIZE-1:0] rsp_data;
    logic [CW-1:0]   occupied_count;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;

    logic [SIZE-1:0] mem   [DEPTH];
    int              board [DEPTH];

    placed_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .occupied_count(occupied_count),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_write_en(ram_write_en), .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_write_en && int'(ram_address) < DEPTH) mem[ram_address] <= ram_write_data;
        ram_read_data <= (int'(ram_address) < DEPTH) ? mem[ram_address] : '0;
        if (ram_write_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (board[i] != 0) c++;
        return c;
    endfunction

    task automatic issue(input logic [1:0] op, input int a, input int d, output int base);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(a); cmd_data = SIZE'(d);
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_ready", int'(cmd_ready), 1);
        base = wr_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Issue one command, predict its outcome from the board model, check everything.
    task automatic do_cmd(input logic [1:0] op, input int a, input int d);
        int exp_st, exp_dat, exp_lat, exp_wr, lat, base;
        exp_dat = 0; exp_wr = 0; exp_lat = 3; exp_st = OK;
        if (op == CLEAR) begin
            for (int i = 0; i < DEPTH; i++) board[i] = 0;
            exp_lat = DEPTH + 1; exp_wr = DEPTH;
        end else if (a >= DEPTH || (op == PLACE && d == 0)) begin
            exp_st = INV; exp_lat = 1;
        end else begin
            exp_dat = board[a];
            if (op == QUERY) exp_st = (board[a] != 0) ? OK : EMP;
            else if (op == PLACE) begin
                if (board[a] == 0) begin board[a] = d; exp_wr = 1; end
                else exp_st = OCC;
            end else begin
                if (board[a] != 0) begin board[a] = 0; exp_wr = 1; end
                else exp_st = EMP;
            end
        end
        issue(op, a, d, base);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, exp_lat);
        chk("status", int'(rsp_status), exp_st);
        chk("data", int'(rsp_data), exp_dat);
        chk("count", int'(occupied_count), model_count());
        chk("writes", wr_cnt - base, exp_wr);
        chk("ready_in_rsp", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("rsp_one_cycle", int'(rsp_valid), 0);
        chk("status_hold", int'(rsp_status), exp_st);
        chk("ready_after", int'(cmd_ready), 1);
    endtask

    initial begin
        int base, n;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = SIZE'($urandom); board[i] = 0; end
        #1;
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_status", int'(rsp_status), 0);
        chk("rst_data", int'(rsp_data), 0);
        chk("rst_count", int'(occupied_count), 0);
        chk("rst_we", int'(ram_write_en), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(cmd_ready), 1);

        // Directed scenarios.
        do_cmd(CLEAR, 0, 0);
        do_cmd(PLACE, 3, 8'h15);
        do_cmd(QUERY, 3, 0);
        do_cmd(PLACE, 3, 8'h22);
        do_cmd(REMOVE, 3, 0);
        do_cmd(REMOVE, 3, 0);
        do_cmd(PLACE, 9, 8'h44);
        do_cmd(PLACE, 2, 0);
        do_cmd(QUERY, 15, 0);
        for (int i = 0; i < DEPTH; i++) do_cmd(PLACE, i, 8'h30 + i);
        do_cmd(PLACE, 5, 8'h77);
        do_cmd(CLEAR, 0, 0);
        for (int i = 0; i < DEPTH; i++) do_cmd(QUERY, i, 0);

        // Reset in the middle of CLEAR, at its 4th write.
        do_cmd(PLACE, 1, 8'h5a);
        do_cmd(PLACE, 6, 8'ha5);
        issue(CLEAR, 0, 0, base);
        n = 0;
        while (wr_cnt - base < 3 && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        chk("clr_4th_we", int'(ram_write_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", int'(rsp_valid), 0);
        chk("abort_status", int'(rsp_status), 0);
        chk("abort_data", int'(rsp_data), 0);
        chk("abort_count", int'(occupied_count), 0);
        chk("abort_addr", int'(ram_address), 0);
        chk("abort_wdata", int'(ram_write_data), 0);
        chk("abort_we", int'(ram_write_en), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_no_rsp2", int'(rsp_valid), 0);
        do_cmd(CLEAR, 0, 0);

        // Randomized commands against the board model.
        for (int k = 0; k < 300; k++) begin
            logic [1:0] op;
            int a, d;
            op = ($urandom_range(0, 19) == 0) ? CLEAR : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 15) : $urandom_range(0, DEPTH - 1);
            d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            do_cmd(op, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
